// File: rtl/cpu_types.sv
// Shared CPU data-bus types: access-size encoding, MMIO register offsets
// and STATUS register bit positions.
package cpu_types;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } memory_mask_t;

  localparam logic [3:0] MMIO_TXDATA = 4'h0;
  localparam logic [3:0] MMIO_STATUS = 4'h4;
  localparam logic [3:0] MMIO_CYCLES = 4'h8;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_ERR_ALIGN = 2;
  localparam int unsigned ST_ERR_OVF   = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Stale storage is masked so the head reads zero whenever nothing is queued.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-bus responder: word-organised RAM with byte/halfword/word lanes,
// plus an MMIO window with a transmit FIFO, status register and cycle counter.
module data_bus_responder
  import cpu_types::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  memory_address,
  input  logic [31:0]  memory_write,
  input  memory_mask_t memory_mask,
  input  logic         memory_we,
  output logic [31:0]  memory_out,
  output logic         misaligned,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready
);
  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                               input memory_mask_t m,
                                               input logic [1:0] off);
    case (m)
      MEM_BYTE:     return {24'b0, w[{off, 3'b000} +: 8]};
      MEM_HALFWORD: return {16'b0, w[{off[1], 4'b0000} +: 16]};
      MEM_WORD:     return w;
      default:      return '0;
    endcase
  endfunction

  function automatic logic [31:0] lane_insert(input logic [31:0] old,
                                              input logic [31:0] d,
                                              input memory_mask_t m,
                                              input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (m)
      MEM_BYTE:     r[{off, 3'b000} +: 8]     = d[7:0];
      MEM_HALFWORD: r[{off[1], 4'b0000} +: 16] = d[15:0];
      MEM_WORD:     r = d;
      default:      r = old;
    endcase
    return r;
  endfunction

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [1:0]    off;
  logic          mask_known, access_ok;
  logic          in_ram, in_mmio;
  logic          ram_we, mmio_we;
  logic [3:0]    mmio_reg;
  logic [31:0]   rd_word, status_word, cycles, wr_word;
  logic          err_align, err_ovf;
  logic          fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          align_set, ovf_set;

  assign ram_idx    = memory_address[AW+1:2];
  assign off        = memory_address[1:0];
  assign mmio_reg   = {memory_address[3:2], 2'b00};
  assign in_ram     = (memory_address < MMIO_BASE);
  assign in_mmio    = (memory_address[31:4] == MMIO_BASE[31:4]);
  assign mask_known = (memory_mask == MEM_BYTE) || (memory_mask == MEM_HALFWORD) ||
                      (memory_mask == MEM_WORD);
  assign misaligned = ((memory_mask == MEM_HALFWORD) && off[0]) ||
                      ((memory_mask == MEM_WORD) && (off != 2'b00));
  assign access_ok  = mask_known && !misaligned;
  assign ram_we     = memory_we && access_ok && in_ram;
  assign mmio_we    = memory_we && access_ok && in_mmio;
  assign fifo_push  = mmio_we && (mmio_reg == MMIO_TXDATA);
  // Store data lane-positioned so sub-word W1C/CYCLES writes hit the addressed bits.
  assign wr_word    = lane_insert('0, memory_write, memory_mask, off);
  assign align_set  = memory_we && misaligned;
  assign ovf_set    = fifo_push && fifo_full && !tx_ready;
  assign tx_valid   = !fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (tx_ready),
    .din   (memory_write[7:0]),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                   = '0;
    status_word[ST_FULL]          = fifo_full;
    status_word[ST_EMPTY]         = fifo_empty;
    status_word[ST_ERR_ALIGN]     = err_align;
    status_word[ST_ERR_OVF]       = err_ovf;
    status_word[ST_COUNT_LSB +: CW] = fifo_count;
  end

  always_comb begin
    rd_word = '0;
    if (in_ram) begin
      rd_word = ram[ram_idx];
    end else if (in_mmio) begin
      case (mmio_reg)
        MMIO_STATUS: rd_word = status_word;
        MMIO_CYCLES: rd_word = cycles;
        default:     rd_word = '0;
      endcase
    end
    memory_out = access_ok ? lane_extract(rd_word, memory_mask, off) : '0;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= lane_insert(ram[ram_idx], memory_write, memory_mask, off);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles    <= '0;
      err_align <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (mmio_we && (mmio_reg == MMIO_CYCLES))
        cycles <= lane_insert(cycles, memory_write, memory_mask, off);
      else
        cycles <= cycles + 1'b1;
      // A set in the same cycle as a W1C clear takes priority.
      if (align_set)
        err_align <= 1'b1;
      else if (mmio_we && (mmio_reg == MMIO_STATUS) && wr_word[ST_ERR_ALIGN])
        err_align <= 1'b0;
      if (ovf_set)
        err_ovf <= 1'b1;
      else if (mmio_we && (mmio_reg == MMIO_STATUS) && wr_word[ST_ERR_OVF])
        err_ovf <= 1'b0;
    end
  end

endmodule
